// File: rtl/rr_arb4_dc.sv
// Four-requester round-robin arbiter with a registered one-hot grant and a
// per-owner hold limit that forces a handover once others have been waiting.
module rr_arb4_dc #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);
  localparam bit               HOLD_EN  = (MAX_HOLD != 0);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [2:0]       pick;

  // Round-robin scan starting after last; {found, index}. excl skips last itself.
  function automatic logic [2:0] rr_pick(input logic [3:0] r,
                                         input logic [1:0] last,
                                         input logic       excl);
    logic [2:0] res;
    logic [1:0] pos;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      pos = last + 2'(k);
      if (r[pos] && !(excl && (k == 4))) res = {1'b1, pos};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      vld_q   <= 1'b0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    pick    = 3'b000;

    if (!ena) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      cnt_d   = '0;
      if (state_q == GRANT) last_d = idx_q;
    end else begin
      case (state_q)
        IDLE: begin
          pick = rr_pick(req, last_q, 1'b0);
          vld_d = pick[2];
          cnt_d = '0;
          if (pick[2]) begin
            idx_d   = pick[1:0];
            state_d = GRANT;
          end
        end
        GRANT: begin
          pick = rr_pick(req, idx_q, 1'b1);
          if (!req[idx_q]) begin
            // Owner released: hand over in the same edge, or fall back to idle.
            last_d = idx_q;
            cnt_d  = '0;
            if (pick[2]) begin
              idx_d = pick[1:0];
            end else begin
              vld_d   = 1'b0;
              state_d = IDLE;
            end
          end else if (!HOLD_EN || (cnt_q < HOLD_LIM)) begin
            if (HOLD_EN) cnt_d = cnt_q + CNT_W'(1);
          end else if (pick[2]) begin
            last_d = idx_q;
            idx_d  = pick[1:0];
            cnt_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    gnt_d = vld_d ? (4'b0001 << idx_d) : 4'b0000;
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;

endmodule

// File: tb/tb_rr_arb4_dc.sv
// Scoreboard bench for rr_arb4_dc: instance A uses the default hold limit,
// instance B runs with an unlimited hold.
module tb_rr_arb4_dc;

  logic       clk;
  logic       rst_n;
  logic       ena_a, ena_b;
  logic [3:0] req_a, req_b;
  logic [3:0] gnt_a, gnt_b;
  logic [1:0] idx_a, idx_b;
  logic       vld_a, vld_b;

  int n_checks;
  int n_errors;

  // Expected entry: {sel, vld, idx[1:0], gnt[3:0]}
  logic [7:0] exp_q[$];
  string      name_q[$];

  rr_arb4_dc #(.MAX_HOLD(8), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a)
  );

  rr_arb4_dc #(.MAX_HOLD(0), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] oh_idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Monitor: pops one expectation per cycle in which the driver issued one.
  always @(negedge clk) begin
    logic [7:0] e;
    logic [3:0] ag;
    logic [1:0] ai;
    logic       av;
    string      nm;
    if (rst_n) begin
      n_checks++;
      if ($countones(gnt_a) > 1 || $countones(gnt_b) > 1) begin
        n_errors++;
        $display("FAIL onehot: gnt_a=%b gnt_b=%b required at most one bit set", gnt_a, gnt_b);
      end
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      ag = e[7] ? gnt_b : gnt_a;
      ai = e[7] ? idx_b : idx_a;
      av = e[7] ? vld_b : vld_a;
      n_checks++;
      if (ag !== e[3:0] || av !== e[6] || (e[6] && ai !== e[5:4])) begin
        n_errors++;
        $display("FAIL %s: got gnt=%b vld=%b idx=%0d required gnt=%b vld=%b idx=%0d",
                 nm, ag, av, ai, e[3:0], e[6], e[5:4]);
      end
    end
  end

  // Drive one cycle of inputs; the expected outputs after the next edge go to the scoreboard.
  task automatic step(input bit sel, input logic [3:0] r, input logic e,
                      input logic [3:0] eg, input string nm);
    if (sel) begin req_b = r; ena_b = e; end
    else     begin req_a = r; ena_a = e; end
    @(posedge clk);
    exp_q.push_back({sel, |eg, oh_idx(eg), eg});
    name_q.push_back(nm);
    #1;
  endtask

  task automatic check_rst(input string nm);
    n_checks++;
    if (gnt_a !== 4'b0000 || vld_a !== 1'b0 || idx_a !== 2'd0 ||
        gnt_b !== 4'b0000 || vld_b !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: got gnt_a=%b vld_a=%b idx_a=%0d gnt_b=%b vld_b=%b required all zero",
               nm, gnt_a, vld_a, idx_a, gnt_b, vld_b);
    end
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_rst(nm);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    ena_a = 1'b1; ena_b = 1'b1;
    req_a = 4'b0000; req_b = 4'b0000;

    do_reset("reset_state");

    // Full contention: 8 cycles per owner, wrapping back to 0.
    for (int i = 0; i < 8; i++) step(0, 4'b1111, 1'b1, 4'b0001, "rr_own0");
    for (int i = 0; i < 8; i++) step(0, 4'b1111, 1'b1, 4'b0010, "rr_own1");
    for (int i = 0; i < 8; i++) step(0, 4'b1111, 1'b1, 4'b0100, "rr_own2");
    for (int i = 0; i < 8; i++) step(0, 4'b1111, 1'b1, 4'b1000, "rr_own3");
    step(0, 4'b1111, 1'b1, 4'b0001, "rr_wrap");
    step(0, 4'b0000, 1'b1, 4'b0000, "rr_idle");

    // Single requester then last-pointer priority.
    do_reset("reset_again");
    for (int i = 0; i < 3; i++) step(0, 4'b0100, 1'b1, 4'b0100, "single2");
    step(0, 4'b0000, 1'b1, 4'b0000, "single2_rel");
    step(0, 4'b0101, 1'b1, 4'b0001, "last2_pick0");
    step(0, 4'b0000, 1'b1, 4'b0000, "pick0_rel");

    // Handover without bubble.
    step(0, 4'b0010, 1'b1, 4'b0010, "own1");
    step(0, 4'b1000, 1'b1, 4'b1000, "release_to3");
    step(0, 4'b0000, 1'b1, 4'b0000, "own3_rel");

    // ena drop while owner 2 holds.
    step(0, 4'b0100, 1'b1, 4'b0100, "own2");
    step(0, 4'b0110, 1'b0, 4'b0000, "ena_low");
    step(0, 4'b0110, 1'b1, 4'b0010, "ena_resume");
    step(0, 4'b0110, 1'b1, 4'b0010, "ena_hold1");
    step(0, 4'b0000, 1'b1, 4'b0000, "own1_rel");

    // Saturated owner preempted as soon as another request appears.
    for (int i = 0; i < 10; i++) step(0, 4'b0001, 1'b1, 4'b0001, "sat_hold0");
    step(0, 4'b0101, 1'b1, 4'b0100, "late_preempt");
    step(0, 4'b0000, 1'b1, 4'b0000, "late_rel");

    // Reset mid-grant restores requester-0 priority.
    step(0, 4'b1000, 1'b1, 4'b1000, "own3_pre_rst");
    req_a = 4'b1001;
    do_reset("async_clear");
    step(0, 4'b1001, 1'b1, 4'b0001, "post_rst_pick0");
    step(0, 4'b0000, 1'b1, 4'b0000, "post_rst_rel");

    // Unlimited hold instance.
    for (int i = 0; i < 20; i++) step(1, 4'b0011, 1'b1, 4'b0001, "nolim_hold0");
    step(1, 4'b0010, 1'b1, 4'b0010, "nolim_rel_to1");
    step(1, 4'b0000, 1'b1, 4'b0000, "nolim_idle");

    begin
      int budget;
      budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
